uv_pulse_sequencer: RTL

- Timing engine between the front-panel control logic (encoder, buttons, display) and the I2C digipot writer.
- On a fire request it latches the exposure settings: on_time, off_time, repetitions and intensity.
- It runs the on/off cycles with 1 ms resolution and drives the UV enable gate.
- It sends each intensity change (set level on, 0 off) to the I2C writer over a valid/ready handshake.

---
 rtl/uv_pulse_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uv_pulse_sequencer.sv
// UV exposure pulse sequencer: on fire, runs on/off cycles at 1 ms
// resolution, gates the UV enable and pushes digipot codes to an I2C writer.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   arm, fire             arm level (low aborts), start pulse (ARMED only)
//   on_time, off_time     phase lengths in ms
//   repetitions           on/off cycle count (0 runs once)
//   intensity             digipot code for the on phase
//   wr_valid/wr_data/
//   wr_ready              valid/ready write channel to the I2C writer
//   uv_on                 UV gate
//   busy, state           status (state encoding = state_t below)
//   ms_count, rep_count   ms in current phase, completed repetitions
//   done                  one-cycle pulse on normal completion
module uv_pulse_sequencer #(
    parameter int TICKS_PER_MS  = 16000,
    parameter int TW            = 14,
    parameter int MAX_TIME      = 9999,
    parameter int MAX_INTENSITY = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          fire,
    input  logic [TW-1:0] on_time,
    input  logic [TW-1:0] off_time,
    input  logic [TW-1:0] repetitions,
    input  logic [7:0]    intensity,
    output logic          wr_valid,
    output logic [7:0]    wr_data,
    input  logic          wr_ready,
    output logic          uv_on,
    output logic          busy,
    output logic [2:0]    state,
    output logic [TW-1:0] ms_count,
    output logic [TW-1:0] rep_count,
    output logic          done
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_ARMED   = 3'd2,
        S_ON_WR   = 3'd3,
        S_ON      = 3'd4,
        S_OFF_WR  = 3'd5,
        S_OFF     = 3'd6,
        S_STOP_WR = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] ms_q, ms_d;
    logic [TW-1:0] rep_q, rep_d;
    logic [TW-1:0] on_q, on_d;
    logic [TW-1:0] off_q, off_d;
    logic [TW-1:0] reps_q, reps_d;
    logic [7:0]    int_q, int_d;
    logic          abort_q, abort_d;
    logic          acc_q;
    logic          done_q, done_d;

    logic          accept;
    logic          abort;
    logic          tick;
    logic          end_off;
    logic          wr_state;
    logic [TW-1:0] ms_inc;
    logic [TW-1:0] rep_inc;

    assign ms_inc  = ms_q + TW'(1);
    assign rep_inc = rep_q + TW'(1);
    assign tick    = (presc_q == PW'(TICKS_PER_MS - 1));

    assign wr_state = (state_q == S_INIT) || (state_q == S_ON_WR) ||
                      (state_q == S_OFF_WR) || (state_q == S_STOP_WR);
    // acc_q inserts one idle cycle after every accepted write
    assign wr_valid = !rst && wr_state && !acc_q;
    assign wr_data  = (state_q == S_ON_WR) ? int_q : 8'd0;
    assign accept   = wr_valid && wr_ready;

    // abort_q keeps an abort alive while a request is still outstanding
    assign abort = !arm || abort_q;

    assign uv_on     = (state_q == S_ON) && arm;
    assign busy      = !rst && (state_q != S_IDLE) && (state_q != S_ARMED);
    assign state     = state_q;
    assign ms_count  = ms_q;
    assign rep_count = rep_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        rep_d   = rep_q;
        on_d    = on_q;
        off_d   = off_q;
        reps_d  = reps_q;
        int_d   = int_q;
        abort_d = abort_q;
        done_d  = 1'b0;
        end_off = 1'b0;

        unique case (state_q)
            S_INIT: begin
                if (accept) state_d = S_IDLE;
            end
            S_IDLE: begin
                abort_d = 1'b0;
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    on_d    = (on_time > TW'(MAX_TIME)) ? TW'(MAX_TIME) : on_time;
                    off_d   = (off_time > TW'(MAX_TIME)) ? TW'(MAX_TIME) : off_time;
                    reps_d  = (repetitions > TW'(MAX_TIME)) ? TW'(MAX_TIME) :
                              (repetitions == '0) ? TW'(1) : repetitions;
                    int_d   = (intensity > 8'(MAX_INTENSITY)) ?
                              8'(MAX_INTENSITY) : intensity;
                    rep_d   = '0;
                    ms_d    = '0;
                    presc_d = '0;
                    state_d = S_ON_WR;
                end
            end
            S_ON_WR: begin
                if (abort) begin
                    abort_d = 1'b1;
                    // digipot already at 0 if nothing is being presented
                    if (accept) state_d = (int_q == 8'd0) ? S_IDLE : S_STOP_WR;
                    else if (!wr_valid) state_d = S_IDLE;
                end else if (accept) begin
                    if (on_q == '0) begin
                        state_d = S_OFF_WR;
                    end else begin
                        state_d = S_ON;
                        presc_d = '0;
                        ms_d    = '0;
                    end
                end
            end
            S_ON: begin
                if (abort) begin
                    state_d = S_STOP_WR;
                end else if (tick) begin
                    presc_d = '0;
                    ms_d    = ms_inc;
                    if (ms_inc == on_q) state_d = S_OFF_WR;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_OFF_WR: begin
                if (abort) begin
                    abort_d = 1'b1;
                    // idle gap: digipot still holds the on level
                    if (accept) state_d = S_IDLE;
                    else if (!wr_valid) state_d = S_STOP_WR;
                end else if (accept) begin
                    if (off_q == '0) begin
                        end_off = 1'b1;
                    end else begin
                        state_d = S_OFF;
                        presc_d = '0;
                        ms_d    = '0;
                    end
                end
            end
            S_OFF: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    presc_d = '0;
                    ms_d    = ms_inc;
                    if (ms_inc == off_q) end_off = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_STOP_WR: begin
                if (accept) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase

        if (end_off) begin
            rep_d = rep_inc;
            if (rep_inc == reps_q) begin
                done_d  = 1'b1;
                state_d = arm ? S_ARMED : S_IDLE;
            end else begin
                state_d = S_ON_WR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            presc_q <= '0;
            ms_q    <= '0;
            rep_q   <= '0;
            on_q    <= '0;
            off_q   <= '0;
            reps_q  <= '0;
            int_q   <= '0;
            abort_q <= 1'b0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            ms_q    <= ms_d;
            rep_q   <= rep_d;
            on_q    <= on_d;
            off_q   <= off_d;
            reps_q  <= reps_d;
            int_q   <= int_d;
            abort_q <= abort_d;
            acc_q   <= accept;
            done_q  <= done_d;
        end
    end

endmodule
